// File: rtl/monostable_pkg.sv
// Shared definitions for the monostable timer bank: channel state encoding,
// microsecond rate constant and tick accumulator width.
package monostable_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_e;

    localparam logic [31:0] USEC_HZ = 32'd1_000_000;
    localparam int          ACC_W   = 32;

endpackage

// File: rtl/monostable_chan.sv
// One monostable timer channel: IDLE/RUN control, microsecond down-counter and
// remaining-fraction output (exact divider only when MONOSTABLE_BANK_FRAC_EN is defined).
module monostable_chan
    import monostable_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int FRAC_W = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              i_tick,
    input  logic [CNT_W-1:0]  i_usec,
    input  logic              i_start,
    input  logic              i_retrig,
    input  logic              i_abort,
    output logic              o_active,
    output logic              o_done,
    output logic [FRAC_W-1:0] o_incomplete
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    chan_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_remain, w_remain_nxt;
    logic [CNT_W-1:0]  r_sampled, w_sampled_nxt;
    logic              r_done, w_done_nxt;
    logic [FRAC_W-1:0] r_frac, w_frac_nxt;

    // Next-state logic: abort beats everything, a retrigger reload beats a same-cycle tick
    always_comb begin
        w_state_nxt   = r_state;
        w_remain_nxt  = r_remain;
        w_sampled_nxt = r_sampled;
        w_done_nxt    = 1'b0;
        if (i_abort) begin
            w_state_nxt  = IDLE;
            w_remain_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start && (i_usec == '0)) begin
                        w_done_nxt = 1'b1;
                    end else if (i_start) begin
                        w_state_nxt   = RUN;
                        w_remain_nxt  = i_usec;
                        w_sampled_nxt = i_usec;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                RUN: begin
                    if (i_start && i_retrig) begin
                        w_sampled_nxt = i_usec;
                        if (i_usec == '0) begin
                            w_state_nxt  = IDLE;
                            w_remain_nxt = '0;
                            w_done_nxt   = 1'b1;
                        end else begin
                            w_remain_nxt = i_usec;
                        end
                    end else if (i_tick) begin
                        if (r_remain > CNT_ONE) begin
                            w_remain_nxt = r_remain - CNT_ONE;
                        end else begin
                            w_state_nxt  = IDLE;
                            w_remain_nxt = '0;
                            w_done_nxt   = 1'b1;
                        end
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
                default: begin
                    w_state_nxt  = IDLE;
                    w_remain_nxt = '0;
                end
            endcase
        end
    end

`ifdef MONOSTABLE_BANK_FRAC_EN
    localparam int                PROD_W   = CNT_W + FRAC_W;
    localparam logic [FRAC_W-1:0] FRAC_MAX = '1;

    logic [PROD_W-1:0] w_prod;

    // Remaining fraction; remain never exceeds sampled, so the quotient fits FRAC_W bits
    always_comb begin
        w_prod     = '0;
        w_frac_nxt = '0;
        if ((r_state == RUN) && (r_sampled != '0)) begin
            w_prod     = PROD_W'(r_remain) * PROD_W'(FRAC_MAX);
            w_frac_nxt = FRAC_W'(w_prod / PROD_W'(r_sampled));
        end else begin
            w_frac_nxt = '0;
        end
    end
`else
    // Without the divider the fraction degrades to a running flag
    always_comb begin
        w_frac_nxt = '0;
        if (r_state == RUN) begin
            w_frac_nxt = '1;
        end else begin
            w_frac_nxt = '0;
        end
    end
`endif

    // Channel registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= IDLE;
            r_remain  <= '0;
            r_sampled <= '0;
            r_done    <= 1'b0;
            r_frac    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_remain  <= w_remain_nxt;
            r_sampled <= w_sampled_nxt;
            r_done    <= w_done_nxt;
            r_frac    <= w_frac_nxt;
        end
    end

    assign o_active     = (r_state == RUN);
    assign o_done       = r_done;
    assign o_incomplete = r_frac;

endmodule

// File: rtl/monostable_bank.sv
// Bank of independent monostable timers sharing one 1 us tick prescaler.
// Define MONOSTABLE_BANK_FRAC_EN for the exact remaining-fraction divider.
module monostable_bank
    import monostable_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 32,
    parameter int FRAC_W   = 8
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [31:0]                sys_clk_freq,
    input  logic [CHANNELS*CNT_W-1:0]  usec,
    input  logic [CHANNELS-1:0]        start,
    input  logic [CHANNELS-1:0]        retrig,
    input  logic [CHANNELS-1:0]        abort,
    output logic [CHANNELS-1:0]        active,
    output logic [CHANNELS-1:0]        done,
    output logic [CHANNELS*FRAC_W-1:0] incomplete
);

    logic [ACC_W-1:0] r_acc, w_acc_nxt;
    logic             r_tick, w_tick_nxt;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W:0]   w_freq_ext;

    // Phase accumulator; the extra sum bit keeps the compare exact, so freq <= 1 MHz ticks every cycle
    always_comb begin
        w_freq_ext = {1'b0, sys_clk_freq};
        w_sum      = {1'b0, r_acc} + {1'b0, USEC_HZ};
        w_acc_nxt  = r_acc;
        w_tick_nxt = 1'b0;
        if (w_sum >= w_freq_ext) begin
            w_acc_nxt  = ACC_W'(w_sum - w_freq_ext);
            w_tick_nxt = 1'b1;
        end else begin
            w_acc_nxt  = ACC_W'(w_sum);
            w_tick_nxt = 1'b0;
        end
    end

    // Prescaler registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_acc  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_acc  <= w_acc_nxt;
            r_tick <= w_tick_nxt;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        monostable_chan #(
            .CNT_W  (CNT_W),
            .FRAC_W (FRAC_W)
        ) u_chan (
            .sys_clk      (sys_clk),
            .sys_rst      (sys_rst),
            .i_tick       (r_tick),
            .i_usec       (usec[g*CNT_W +: CNT_W]),
            .i_start      (start[g]),
            .i_retrig     (retrig[g]),
            .i_abort      (abort[g]),
            .o_active     (active[g]),
            .o_done       (done[g]),
            .o_incomplete (incomplete[g*FRAC_W +: FRAC_W])
        );
    end

endmodule

// File: doc/monostable_bank.md
MONOSTABLE_BANK -- requirements
Module: monostable_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent timer channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32, width of each channel's microsecond count.
REQ-003 SHALL have parameter FRAC_W, default 8, width of each channel's remaining-fraction output.
REQ-004 SHALL have port sys_clk  in  1  single clock for all logic.
REQ-005 SHALL have port sys_rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port sys_clk_freq  in  32  sys_clk frequency in Hz.
REQ-007 SHALL have port usec  in  CHANNELS*CNT_W  per-channel duration in microseconds; channel n occupies bits [n*CNT_W +: CNT_W].
REQ-008 SHALL have port start  in  CHANNELS  per-channel trigger, level-sampled each cycle.
REQ-009 SHALL have port retrig  in  CHANNELS  per-channel mode: 1 = retriggerable, 0 = non-retriggerable.
REQ-010 SHALL have port abort  in  CHANNELS  per-channel cancel.
REQ-011 SHALL have port active  out  CHANNELS  channel running.
REQ-012 SHALL have port done  out  CHANNELS  one-cycle completion pulse.
REQ-013 SHALL have port incomplete  out  CHANNELS*FRAC_W  remaining fraction of each channel, scaled to 2^FRAC_W-1.

Function
REQ-014 SHALL generate a shared 1 us tick with a 32-bit phase accumulator: each cycle sum = acc + 1_000_000; if sum >= sys_clk_freq then acc <= sum - sys_clk_freq and tick <= 1, else acc <= sum and tick <= 0.
REQ-015 SHALL assert tick every cycle when sys_clk_freq <= 1_000_000, including sys_clk_freq = 0.
REQ-016 SHALL implement per-channel states IDLE and RUN, with registers remain[CNT_W] and sampled[CNT_W].
REQ-017 SHALL, in IDLE with start=1 and usec!=0, load remain = sampled = usec and enter RUN; active SHALL rise the next cycle.
REQ-018 SHALL, in IDLE with start=1 and usec=0, stay in IDLE and pulse done the next cycle.
REQ-019 SHALL, in RUN with tick=1 and remain>1, decrement remain.
REQ-020 SHALL, in RUN with tick=1 and remain=1, set remain=0, enter IDLE and pulse done, so that done is high in the cycle after the final tick.
REQ-021 SHALL, in RUN with start=1 and retrig=1, reload remain and sampled from usec; the reload wins over a same-cycle tick; a reload with usec=0 behaves as completion per REQ-020.
REQ-022 SHALL, in RUN with start=1 and retrig=0, ignore start.
REQ-023 SHALL give abort priority over start and tick in either state: enter IDLE, remain=0, no done pulse.
REQ-024 SHALL keep channels fully independent apart from the shared tick; simultaneous events on different channels SHALL not interact.
REQ-025 SHALL register incomplete as (remain*(2^FRAC_W-1))/sampled, computed in CNT_W+FRAC_W bits, one cycle after remain updates; incomplete SHALL be 0 whenever sampled=0 or the channel is IDLE.

Reset
REQ-026 SHALL, on sys_rst=1 at a sys_clk edge, clear acc, tick, remain, sampled and state (to IDLE), and drive active=0, done=0 and incomplete=0 the following cycle.
REQ-027 SHALL, when reset arrives mid-run, discard the run without producing a done pulse; start is ignored while sys_rst=1.

Configuration
REQ-028 SHALL, with macro MONOSTABLE_BANK_FRAC_EN defined, implement the divider of REQ-025.
REQ-029 SHALL, without MONOSTABLE_BANK_FRAC_EN, omit the divider and drive incomplete per channel to all-ones while active=1 and to 0 otherwise, with the same one-cycle latency.

Structure
REQ-030 SHALL place in shared package monostable_pkg: the state enum (IDLE, RUN), the constant USEC_HZ = 1_000_000, and the accumulator width constant.
REQ-031 SHALL implement one channel (state machine, counters, fraction) as sub-module monostable_chan, instantiated CHANNELS times; the prescaler SHALL remain in the top level.

Verification
REQ-032 SHALL cover: sys_clk_freq=4_000_000, usec[0]=3, start[0] for 1 cycle -> active[0] high 9..12 cycles, then done[0] pulses exactly 1 cycle; other channels stay idle.
REQ-033 SHALL cover: sys_clk_freq=1_000_000, usec=10, retrig=1, start re-pulsed 5 cycles after the first start -> done 1 cycle after the 10th tick following the re-pulse (no earlier done); with retrig=0 the same stimulus gives done after the 10th tick following the first start.
REQ-034 SHALL cover: abort asserted 2 cycles after start (usec=100) -> active low the next cycle, no done pulse, incomplete=0; abort and start asserted together -> channel stays IDLE.
REQ-035 SHALL cover: start with usec=0 -> done pulse 1 cycle later, active never high.
REQ-036 SHALL cover, with MONOSTABLE_BANK_FRAC_EN: sys_clk_freq=1_000_000, usec=4, FRAC_W=8 -> incomplete sequence 255, 191, 127, 63, 0.
REQ-037 SHALL cover: sys_rst asserted mid-run on all 4 channels -> active=0, done=0, incomplete=0 the next cycle, and a fresh start runs normally afterwards.
